// File: rtl/branch_pkg.sv
// -----------------------------------------------------------------------------
// branch_pkg
// Shared types and constants for the branch prediction controller.
//   ctr_t       : 2-bit saturating direction counter encoding
//   bp_state_t  : controller state (table-clear sweep / normal operation)
//   bp_entry_t  : one BTB entry (valid, tag, target, counter)
//   CTR_RESET   : counter value written by the clear sweep
//   CTR_ALLOC   : counter value written when a taken branch allocates
// The tag field is sized for the widest possible tag (ENTRIES=4); smaller
// tags are stored zero-extended so the struct does not depend on ENTRIES.
// -----------------------------------------------------------------------------
package branch_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } bp_state_t;

    localparam int TAG_MAX_W = 28;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [31:0]          target;
        ctr_t                 ctr;
    } bp_entry_t;

    localparam ctr_t CTR_RESET = WNT;
    localparam ctr_t CTR_ALLOC = WT;

    // Contents written into every entry by the table-clear sweep.
    function automatic bp_entry_t entry_reset();
        bp_entry_t e;
        e.valid  = 1'b0;
        e.tag    = {TAG_MAX_W{1'b0}};
        e.target = 32'd0;
        e.ctr    = CTR_RESET;
        return e;
    endfunction

endpackage

// File: rtl/bp_ctr_update.sv
// -----------------------------------------------------------------------------
// bp_ctr_update
// Combinational 2-bit saturating counter update.
//   cur   : current counter value
//   taken : resolved branch outcome
//   nxt   : next counter value (moves one step toward the outcome,
//           saturating at SNT and ST)
// -----------------------------------------------------------------------------
module bp_ctr_update
    import branch_pkg::*;
(
    input  ctr_t cur,
    input  logic taken,
    output ctr_t nxt
);

    // Saturating step toward the resolved direction.
    always_comb begin
        nxt = cur;
        case (cur)
            SNT:     nxt = taken ? WNT : SNT;
            WNT:     nxt = taken ? WT  : SNT;
            WT:      nxt = taken ? ST  : WNT;
            ST:      nxt = taken ? ST  : WT;
            default: nxt = CTR_RESET;
        endcase
    end

endmodule

// File: rtl/branch_pred_ctrl.sv
// -----------------------------------------------------------------------------
// branch_pred_ctrl
// Branch prediction and resolution controller for the RV32 core.
// A direct-mapped BTB of 2-bit counters predicts taken/target for the fetch
// PC; resolved EX-stage branches raise redirect/flush on a mispredict and
// train the table. After reset a sweep clears one entry per cycle.
//
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   if_pc              : fetch PC
//   pred_taken/target  : prediction for if_pc (target 0 when not taken)
//   ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target,
//   ex_pred_taken, ex_pred_target : resolved branch info from EX
//   redirect, redirect_pc, flush  : mispredict recovery (same cycle as EX)
//   init_busy          : table-clear sweep in progress
//
// Optional feature (macro BRANCH_PERF_CNT_EN):
//   perf_branches, perf_mispred : wrapping 32-bit event counters
// -----------------------------------------------------------------------------
module branch_pred_ctrl
    import branch_pkg::*;
#(
    parameter int ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        init_busy
`ifdef BRANCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_branches,
    output logic [31:0] perf_mispred
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    bp_state_t        state_r;
    logic [IDX_W-1:0] sweep_idx_r;
    logic             init_busy_r;
    bp_entry_t        table_r [ENTRIES];

    logic [IDX_W-1:0]     if_idx_s;
    logic [TAG_MAX_W-1:0] if_tag_s;
    bp_entry_t            if_entry_s;

    logic [IDX_W-1:0]     ex_idx_s;
    logic [TAG_MAX_W-1:0] ex_tag_s;
    bp_entry_t            ex_entry_s;
    logic                 ex_hit_s;
    logic                 ex_branch_s;
    logic                 train_s;
    logic                 mis_s;
    ctr_t                 ctr_next_s;

    logic                 unused_ok_s;

    assign if_idx_s   = if_pc[IDX_W+1:2];
    assign if_tag_s   = TAG_MAX_W'(if_pc[31:IDX_W+2]);
    assign if_entry_s = table_r[if_idx_s];

    assign ex_idx_s    = ex_pc[IDX_W+1:2];
    assign ex_tag_s    = TAG_MAX_W'(ex_pc[31:IDX_W+2]);
    assign ex_entry_s  = table_r[ex_idx_s];
    assign ex_hit_s    = ex_entry_s.valid && (ex_entry_s.tag == ex_tag_s);
    assign ex_branch_s = ex_valid && ex_is_branch;
    assign train_s     = ex_branch_s && (state_r == RUN);

    // Fetch PC low bits and the EX-side target read are not needed.
    assign unused_ok_s = ^{if_pc[1:0], ex_entry_s.target};

    bp_ctr_update u_ctr_update (
        .cur   (ex_entry_s.ctr),
        .taken (ex_taken),
        .nxt   (ctr_next_s)
    );

    // Prediction from the registered table; gated off during the clear sweep.
    always_comb begin
        pred_taken  = 1'b0;
        pred_target = 32'd0;
        if ((state_r == RUN) && if_entry_s.valid &&
            (if_entry_s.tag == if_tag_s) && if_entry_s.ctr[1]) begin
            pred_taken  = 1'b1;
            pred_target = if_entry_s.target;
        end else begin
            pred_taken  = 1'b0;
            pred_target = 32'd0;
        end
    end

    // Mispredict detection and recovery PC; independent of table state.
    always_comb begin
        mis_s       = ex_branch_s &&
                      ((ex_taken != ex_pred_taken) ||
                       (ex_taken && (ex_target != ex_pred_target)));
        redirect_pc = 32'd0;
        if (mis_s) begin
            redirect_pc = ex_taken ? ex_target : (ex_pc + 32'd4);
        end else begin
            redirect_pc = 32'd0;
        end
    end

    assign redirect  = mis_s;
    assign flush     = mis_s;
    assign init_busy = init_busy_r;

    // Controller state and sweep index; sweep ends after ENTRIES cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= INIT;
            sweep_idx_r <= '0;
            init_busy_r <= 1'b1;
        end else begin
            case (state_r)
                INIT: begin
                    if (sweep_idx_r == IDX_W'(ENTRIES - 1)) begin
                        state_r     <= RUN;
                        sweep_idx_r <= '0;
                        init_busy_r <= 1'b0;
                    end else begin
                        sweep_idx_r <= sweep_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                    end
                end
                RUN: begin
                    state_r     <= RUN;
                    init_busy_r <= 1'b0;
                end
                default: begin
                    state_r     <= INIT;
                    sweep_idx_r <= '0;
                    init_busy_r <= 1'b1;
                end
            endcase
        end
    end

    // Table storage: clear sweep in INIT, branch training in RUN. A read of
    // the entry being written this cycle still sees the old contents.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_r == INIT) begin
                table_r[sweep_idx_r] <= entry_reset();
            end else if (train_s) begin
                if (ex_hit_s) begin
                    table_r[ex_idx_s].ctr <= ctr_next_s;
                    if (ex_taken) begin
                        table_r[ex_idx_s].target <= ex_target;
                    end
                end else if (ex_taken) begin
                    table_r[ex_idx_s].valid  <= 1'b1;
                    table_r[ex_idx_s].tag    <= ex_tag_s;
                    table_r[ex_idx_s].target <= ex_target;
                    table_r[ex_idx_s].ctr    <= CTR_ALLOC;
                end
            end
        end
    end

`ifdef BRANCH_PERF_CNT_EN
    // Event counters; they count in INIT too and wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_branches <= 32'd0;
            perf_mispred  <= 32'd0;
        end else begin
            if (ex_branch_s) begin
                perf_branches <= perf_branches + 32'd1;
            end
            if (mis_s) begin
                perf_mispred <= perf_mispred + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// -----------------------------------------------------------------------------
// tb_branch_pred_ctrl
// Directed, table-driven bench for branch_pred_ctrl (ENTRIES=16). Build with
// BRANCH_PERF_CNT_EN defined to also cover the performance counters.
// -----------------------------------------------------------------------------
module tb_branch_pred_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic        ex_is_branch;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        init_busy;
`ifdef BRANCH_PERF_CNT_EN
    logic [31:0] perf_branches;
    logic [31:0] perf_mispred;
`endif

    int total = 0;
    int bad   = 0;
    int exp_br  = 0;
    int exp_mis = 0;

    typedef struct packed {
        logic [31:0] if_pc;
        logic        v;
        logic        b;
        logic [31:0] pc;
        logic        t;
        logic [31:0] tgt;
        logic        pt;
        logic [31:0] ptgt;
        logic        e_pt;
        logic [31:0] e_ptgt;
        logic        e_red;
        logic [31:0] e_rpc;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs [NVEC];

    branch_pred_ctrl #(.ENTRIES(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_is_branch   (ex_is_branch),
        .ex_pc          (ex_pc),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .init_busy      (init_busy)
`ifdef BRANCH_PERF_CNT_EN
        ,
        .perf_branches  (perf_branches),
        .perf_mispred   (perf_mispred)
`endif
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic [31:0] a_if, input logic a_v, input logic a_b,
        input logic [31:0] a_pc, input logic a_t, input logic [31:0] a_tgt,
        input logic a_pt, input logic [31:0] a_ptgt,
        input logic a_ept, input logic [31:0] a_eptgt,
        input logic a_ered, input logic [31:0] a_erpc);
        vec_t r;
        r.if_pc = a_if;  r.v = a_v;   r.b = a_b;    r.pc = a_pc;
        r.t = a_t;       r.tgt = a_tgt; r.pt = a_pt; r.ptgt = a_ptgt;
        r.e_pt = a_ept;  r.e_ptgt = a_eptgt;
        r.e_red = a_ered; r.e_rpc = a_erpc;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic ex_idle();
        ex_valid = 1'b0; ex_is_branch = 1'b0; ex_pc = 32'd0; ex_taken = 1'b0;
        ex_target = 32'd0; ex_pred_taken = 1'b0; ex_pred_target = 32'd0;
    endtask

    // Walks the 17 cycles following reset release: busy for 16, then idle.
    // Optionally resolves a mispredicted taken branch on the last INIT cycle.
    task automatic sweep_check(input logic [31:0] pc, input logic with_branch);
        for (int k = 0; k <= 16; k++) begin
            if_pc = pc;
            if (with_branch && k == 15) begin
                ex_valid = 1'b1; ex_is_branch = 1'b1; ex_pc = 32'h100;
                ex_taken = 1'b1; ex_target = 32'h200;
                ex_pred_taken = 1'b0; ex_pred_target = 32'd0;
            end else begin
                ex_idle();
            end
            #1;
            check($sformatf("sweep%0d init_busy", k), 32'(init_busy), (k < 16) ? 32'd1 : 32'd0);
            check($sformatf("sweep%0d pred_taken", k), 32'(pred_taken), 32'd0);
            if (with_branch && k == 15) begin
                check("init redirect", 32'(redirect), 32'd1);
                check("init redirect_pc", redirect_pc, 32'h200);
                exp_br++;
                exp_mis++;
            end
            @(posedge clk); #1;
        end
        ex_idle();
    endtask

    initial begin
        vecs[0]  = mk(32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h200);
        vecs[1]  = mk(32'h100, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h0);
        vecs[2]  = mk(32'h100, 1'b1, 1'b1, 32'h100, 1'b0, 32'h200, 1'b1, 32'h200, 1'b1, 32'h200, 1'b1, 32'h104);
        vecs[3]  = mk(32'h100, 1'b1, 1'b1, 32'h100, 1'b0, 32'h200, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0);
        vecs[4]  = mk(32'h100, 1'b1, 1'b1, 32'h100, 1'b0, 32'h200, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0);
        vecs[5]  = mk(32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h200);
        vecs[6]  = mk(32'h100, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0);
        vecs[7]  = mk(32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h200);
        vecs[8]  = mk(32'h100, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h0);
        vecs[9]  = mk(32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0, 32'h0);
        vecs[10] = mk(32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0, 32'h0);
        vecs[11] = mk(32'h100, 1'b1, 1'b1, 32'h100, 1'b0, 32'h200, 1'b1, 32'h200, 1'b1, 32'h200, 1'b1, 32'h104);
        vecs[12] = mk(32'h100, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h0);
        vecs[13] = mk(32'h140, 1'b1, 1'b1, 32'h140, 1'b1, 32'h300, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h300);
        vecs[14] = mk(32'h100, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0);
        vecs[15] = mk(32'h140, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h300, 1'b0, 32'h0);
        vecs[16] = mk(32'h140, 1'b1, 1'b1, 32'h140, 1'b1, 32'h240, 1'b1, 32'h200, 1'b1, 32'h300, 1'b1, 32'h240);
        vecs[17] = mk(32'h140, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h240, 1'b0, 32'h0);
        vecs[18] = mk(32'h180, 1'b1, 1'b0, 32'h180, 1'b1, 32'h500, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0);
        vecs[19] = mk(32'h180, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0);
        vecs[20] = mk(32'h3C,  1'b1, 1'b1, 32'hFFFFFFFC, 1'b0, 32'h10, 1'b1, 32'h10, 1'b0, 32'h0, 1'b1, 32'h0);
        vecs[21] = mk(32'hFFFFFFFC, 1'b0, 1'b1, 32'h100, 1'b1, 32'h999, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

        rst = 1'b1;
        if_pc = 32'h100;
        ex_idle();
        repeat (2) @(posedge clk);
        #1;
        check("rst init_busy", 32'(init_busy), 32'd1);
        check("rst pred_taken", 32'(pred_taken), 32'd0);
        check("rst pred_target", pred_target, 32'd0);
        check("rst redirect", 32'(redirect), 32'd0);
        check("rst flush", 32'(flush), 32'd0);
        check("rst redirect_pc", redirect_pc, 32'd0);
`ifdef BRANCH_PERF_CNT_EN
        check("rst perf_branches", perf_branches, 32'd0);
        check("rst perf_mispred", perf_mispred, 32'd0);
`endif
        rst = 1'b0;
        sweep_check(32'h100, 1'b1);

        // Main vector table: one cycle per record, training on the edge after.
        for (int i = 0; i < NVEC; i++) begin
            if_pc          = vecs[i].if_pc;
            ex_valid       = vecs[i].v;
            ex_is_branch   = vecs[i].b;
            ex_pc          = vecs[i].pc;
            ex_taken       = vecs[i].t;
            ex_target      = vecs[i].tgt;
            ex_pred_taken  = vecs[i].pt;
            ex_pred_target = vecs[i].ptgt;
            #1;
            check($sformatf("v%0d pred_taken", i), 32'(pred_taken), 32'(vecs[i].e_pt));
            check($sformatf("v%0d pred_target", i), pred_target, vecs[i].e_ptgt);
            check($sformatf("v%0d redirect", i), 32'(redirect), 32'(vecs[i].e_red));
            check($sformatf("v%0d flush", i), 32'(flush), 32'(vecs[i].e_red));
            check($sformatf("v%0d redirect_pc", i), redirect_pc, vecs[i].e_rpc);
            if (vecs[i].v && vecs[i].b) exp_br++;
            if (vecs[i].e_red) exp_mis++;
            @(posedge clk); #1;
        end
        ex_idle();
        if_pc = 32'h140;
        #1;
        check("trained 0x140 pred_taken", 32'(pred_taken), 32'd1);
`ifdef BRANCH_PERF_CNT_EN
        check("perf_branches", perf_branches, 32'(exp_br));
        check("perf_mispred", perf_mispred, 32'(exp_mis));
`endif

        // Reset mid-RUN: prediction is gated as soon as INIT is entered.
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrun init_busy", 32'(init_busy), 32'd1);
        check("midrun pred_taken", 32'(pred_taken), 32'd0);
`ifdef BRANCH_PERF_CNT_EN
        check("midrun perf_branches", perf_branches, 32'd0);
        check("midrun perf_mispred", perf_mispred, 32'd0);
`endif
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        // Reset mid-INIT: the sweep must restart from entry 0.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sweep_check(32'h140, 1'b0);
        if_pc = 32'h100;
        #1;
        check("cleared 0x100 pred_taken", 32'(pred_taken), 32'd0);
        check("cleared 0x100 pred_target", pred_target, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
